// File: rtl/ahb_byte_loader.sv
// ahb_byte_loader
//   Packs an 8-bit valid/ready byte stream into 32-bit little-endian words and
//   writes them as single non-pipelined NONSEQ word writes on AHB-lite, to
//   consecutive word addresses starting at BASE_ADDR.
//
// Ports
//   HCLK, HRESET        clock, synchronous active-high reset
//   start, len          load request and word count (sampled on accepted start)
//   s_data/s_valid/s_ready  byte stream sink
//   HADDR..HWDATA       AHB-lite master outputs (HSIZE/HBURST/HPROT constant)
//   HREADY, HRESP       AHB-lite slave response
//   busy, done, error   status: not idle, completion pulse, sticky bus error
module ahb_byte_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int unsigned LEN_WIDTH = 12
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [3:0]           HPROT,
    output logic                 HWRITE,
    output logic [31:0]          HWDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_ADDR,
        S_DATA
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [23:0]          word_q, word_d;
    logic [31:0]          hwdata_q, hwdata_d;
    logic [31:0]          haddr_q, haddr_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            hwdata_q <= '0;
            haddr_q  <= BASE_ADDR;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            hwdata_q <= hwdata_d;
            haddr_q  <= haddr_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        hwdata_d = hwdata_q;
        haddr_d  = haddr_q;
        done_d   = 1'b0;
        error_d  = error_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = len;
                    idx_d   = '0;
                    cnt_d   = '0;
                    error_d = 1'b0;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (s_valid) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Full word goes straight to the data register; the
                        // address is computed once so HADDR only moves on
                        // entry to the address phase.
                        hwdata_d = {s_data, word_q};
                        haddr_d  = BASE_ADDR + (32'(idx_q) << 2);
                        state_d  = S_ADDR;
                    end else begin
                        word_d[{cnt_q, 3'b000} +: 8] = s_data;
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (HRESP) begin
                    // Either cycle of the two-cycle error response marks it.
                    error_d = 1'b1;
                    if (HREADY) begin
                        state_d = S_IDLE;
                    end
                end else if (HREADY) begin
                    idx_d = idx_q + LEN_WIDTH'(1);
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign s_ready = (state_q == S_FILL);
    assign HTRANS  = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign HWRITE  = (state_q == S_ADDR);
    assign HADDR   = haddr_q;
    assign HWDATA  = hwdata_q;
    assign HSIZE   = 3'b010;
    assign HBURST  = 3'b000;
    assign HPROT   = 4'b0011;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_ahb_byte_loader.sv
module tb_ahb_byte_loader;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        start = 1'b0;
    logic [11:0] len = '0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    always #5 HCLK = ~HCLK;

    ahb_byte_loader #(.BASE_ADDR(32'h2000_0000), .LEN_WIDTH(12)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP),
        .busy(busy), .done(done), .error(error)
    );

    int checks = 0;
    int failures = 0;

    // Results of the last load run
    logic [7:0]  bytes[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int bpos, n_addr_acc, done_cnt, done_k, end_k, unstable, sready_bad;
    logic err_k1;

    // Drives one load: start pulse, byte stream, AHB slave with wait/error
    // behaviour. Everything is driven and sampled on the falling edge.
    task automatic run_load(input int nlen, input int aw, input int dw,
                            input int err_word, input bit gaps,
                            input bit poke_start, input int rst_word,
                            input int budget);
        logic        dph;
        int          acnt, dcnt, wi;
        logic [31:0] a_first, d_first;
        logic        w_first;
        bit          fin;
        logic [7:0]  gap_pat;
        gap_pat = 8'b1011_0110;
        wr_addr.delete();
        wr_data.delete();
        bpos = 0; n_addr_acc = 0; done_cnt = 0; done_k = -1; end_k = -1;
        unstable = 0; sready_bad = 0; err_k1 = 1'bx;
        dph = 1'b0; acnt = 0; dcnt = 0; wi = 0; fin = 1'b0;
        a_first = '0; d_first = '0; w_first = 1'b0;
        @(negedge HCLK);
        start = 1'b1; len = 12'(nlen); s_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        for (int k = 1; k <= budget && !fin; k++) begin
            @(negedge HCLK);
            start = 1'b0;
            len = 12'hABC;
            if (poke_start && k == 3) begin
                start = 1'b1;
                len = 12'd7;
            end
            if (k == 1) err_k1 = error;
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (!busy) begin
                end_k = k;
                fin = 1'b1;
                s_valid = 1'b0;
                HREADY = 1'b1;
                HRESP = 1'b0;
            end else begin
                if (bpos < bytes.size() && (!gaps || gap_pat[k % 8])) begin
                    s_valid = 1'b1;
                    s_data = bytes[bpos];
                end else begin
                    s_valid = 1'b0;
                    s_data = 8'hEE;
                end
                if (s_valid && s_ready) bpos++;
                HRESP = 1'b0;
                HREADY = 1'b1;
                if (dph) begin
                    if (s_ready) sready_bad++;
                    if (HTRANS !== 2'b00 || HWRITE !== 1'b0) unstable++;
                    if (dcnt == 0) d_first = HWDATA;
                    else if (HWDATA !== d_first) unstable++;
                    if (wi == err_word) begin
                        HRESP = 1'b1;
                        HREADY = (dcnt >= 1);
                    end else begin
                        HREADY = (dcnt >= dw);
                    end
                    if (wi == rst_word) begin
                        HRESET = 1'b1;
                        HREADY = 1'b0;
                        s_valid = 1'b0;
                        fin = 1'b1;
                    end else if (HREADY) begin
                        if (!HRESP) begin
                            wr_addr.push_back(a_first);
                            wr_data.push_back(HWDATA);
                        end
                        dph = 1'b0;
                        wi++;
                    end
                    dcnt++;
                end else if (HTRANS == 2'b10) begin
                    if (s_ready) sready_bad++;
                    if (acnt == 0) begin
                        a_first = HADDR;
                        w_first = HWRITE;
                        if (HWRITE !== 1'b1) unstable++;
                    end else if (HADDR !== a_first || HWRITE !== w_first) begin
                        unstable++;
                    end
                    HREADY = (acnt >= aw);
                    acnt++;
                    if (HREADY) begin
                        n_addr_acc++;
                        dph = 1'b1;
                        dcnt = 0;
                        acnt = 0;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1; start = 1'b1; len = 12'h5A5; s_valid = 1'b1;
        s_data = 8'hC3; HREADY = 1'b0; HRESP = 1'b1;
        repeat (2) @(negedge HCLK);
        checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%h exp=00", HTRANS); end
        checks++; if (HWRITE !== 1'b0) begin failures++; $display("FAIL rst_hwrite got=%b exp=0", HWRITE); end
        checks++; if (HADDR !== BASE) begin failures++; $display("FAIL rst_haddr got=%h exp=%h", HADDR, BASE); end
        checks++; if (HWDATA !== 32'h0) begin failures++; $display("FAIL rst_hwdata got=%h exp=0", HWDATA); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", error); end
        checks++; if (HSIZE !== 3'b010) begin failures++; $display("FAIL rst_hsize got=%b exp=010", HSIZE); end
        checks++; if (HBURST !== 3'b000) begin failures++; $display("FAIL rst_hburst got=%b exp=000", HBURST); end
        checks++; if (HPROT !== 4'b0011) begin failures++; $display("FAIL rst_hprot got=%b exp=0011", HPROT); end
        start = 1'b0; s_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRESET = 1'b0;
        repeat (2) @(negedge HCLK);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_word();
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1, 0, 0, -1, 1'b0, 1'b0, -1, 40);
        checks++; if (end_k != 7) begin failures++; $display("FAIL single_busy_fall got=%0d exp=7", end_k); end
        checks++; if (done_k != 7 || done_cnt != 1) begin failures++; $display("FAIL single_done got=k%0d/n%0d exp=k7/n1", done_k, done_cnt); end
        checks++; if (wr_addr.size() != 1 || n_addr_acc != 1) begin failures++; $display("FAIL single_writes got=%0d/%0d exp=1/1", wr_addr.size(), n_addr_acc); end
        checks++; if (((wr_addr.size() > 0) ? wr_addr[0] : 32'hx) !== BASE) begin failures++; $display("FAIL single_addr got=%h exp=%h", (wr_addr.size() > 0) ? wr_addr[0] : 32'hx, BASE); end
        checks++; if (((wr_data.size() > 0) ? wr_data[0] : 32'hx) !== 32'h4433_2211) begin failures++; $display("FAIL single_data got=%h exp=44332211", (wr_data.size() > 0) ? wr_data[0] : 32'hx); end
        checks++; if (bpos != 4 || sready_bad != 0 || unstable != 0) begin failures++; $display("FAIL single_stream got=b%0d/r%0d/u%0d exp=b4/r0/u0", bpos, sready_bad, unstable); end
    endtask

    task automatic test_multi_gaps();
        logic [31:0] exp_d[3];
        exp_d = '{32'h7654_3210, 32'hFEDC_BA98, 32'h6745_2301};
        bytes = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE,
                  8'h01, 8'h23, 8'h45, 8'h67};
        run_load(3, 0, 0, -1, 1'b1, 1'b0, -1, 200);
        checks++; if (end_k < 0 || done_cnt != 1) begin failures++; $display("FAIL multi_done got=k%0d/n%0d exp=n1", end_k, done_cnt); end
        checks++; if (wr_addr.size() != 3) begin failures++; $display("FAIL multi_count got=%0d exp=3", wr_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (((wr_addr.size() > i) ? wr_addr[i] : 32'hx) !== BASE + 32'(4 * i) ||
                ((wr_data.size() > i) ? wr_data[i] : 32'hx) !== exp_d[i]) begin
                failures++;
                $display("FAIL multi_word%0d got=%h:%h exp=%h:%h", i,
                         (wr_addr.size() > i) ? wr_addr[i] : 32'hx,
                         (wr_data.size() > i) ? wr_data[i] : 32'hx,
                         BASE + 32'(4 * i), exp_d[i]);
            end
        end
        checks++; if (bpos != 12 || sready_bad != 0) begin failures++; $display("FAIL multi_stream got=b%0d/r%0d exp=b12/r0", bpos, sready_bad); end
    endtask

    task automatic test_wait_states();
        bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        run_load(2, 2, 1, -1, 1'b0, 1'b0, -1, 100);
        checks++; if (end_k != 19 || done_k != 19) begin failures++; $display("FAIL wait_timing got=%0d/%0d exp=19/19", end_k, done_k); end
        checks++; if (unstable != 0) begin failures++; $display("FAIL wait_stable got=%0d exp=0", unstable); end
        checks++; if (n_addr_acc != 2 || wr_addr.size() != 2 || sready_bad != 0) begin failures++; $display("FAIL wait_writes got=%0d/%0d/r%0d exp=2/2/r0", n_addr_acc, wr_addr.size(), sready_bad); end
        checks++; if (((wr_data.size() > 1) ? wr_data[1] : 32'hx) !== 32'h0403_0201 || wr_data[0] !== 32'hEFBE_ADDE) begin failures++; $display("FAIL wait_data got=%h,%h exp=efbeadde,04030201", wr_data[0], (wr_data.size() > 1) ? wr_data[1] : 32'hx); end
        checks++; if (((wr_addr.size() > 1) ? wr_addr[1] : 32'hx) !== BASE + 32'h4) begin failures++; $display("FAIL wait_addr1 got=%h exp=%h", (wr_addr.size() > 1) ? wr_addr[1] : 32'hx, BASE + 32'h4); end
    endtask

    task automatic test_error();
        int stray;
        bytes.delete();
        for (int i = 0; i < 16; i++) bytes.push_back(8'(8'h10 + i));
        run_load(4, 0, 0, 1, 1'b0, 1'b0, -1, 100);
        checks++; if (end_k != 14) begin failures++; $display("FAIL err_busy_fall got=%0d exp=14", end_k); end
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL err_flags got=e%b/b%b exp=e1/b0", error, busy); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL err_no_done got=%0d exp=0", done_cnt); end
        checks++; if (n_addr_acc != 2 || wr_addr.size() != 1 || bpos != 8) begin failures++; $display("FAIL err_traffic got=%0d/%0d/b%0d exp=2/1/b8", n_addr_acc, wr_addr.size(), bpos); end
        stray = 0;
        repeat (4) begin
            @(negedge HCLK);
            if (HTRANS !== 2'b00 || busy !== 1'b0 || done !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL err_quiet got=%0d exp=0", stray); end
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", error); end
        bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        run_load(1, 0, 0, -1, 1'b0, 1'b0, -1, 40);
        checks++; if (err_k1 !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL err_clear got=%b/%b exp=0/0", err_k1, error); end
        checks++; if (((wr_addr.size() > 0) ? wr_addr[0] : 32'hx) !== BASE || ((wr_data.size() > 0) ? wr_data[0] : 32'hx) !== 32'hA4A3_A2A1 || done_cnt != 1) begin failures++; $display("FAIL err_reload got=%h:%h/n%0d exp=%h:a4a3a2a1/n1", (wr_addr.size() > 0) ? wr_addr[0] : 32'hx, (wr_data.size() > 0) ? wr_data[0] : 32'hx, done_cnt, BASE); end
    endtask

    task automatic test_len_zero();
        bytes = '{8'h55, 8'h66, 8'h77, 8'h88};
        run_load(0, 0, 0, -1, 1'b0, 1'b0, -1, 20);
        checks++; if (end_k != 1 || done_k != 1 || done_cnt != 1) begin failures++; $display("FAIL len0_done got=%0d/%0d/%0d exp=1/1/1", end_k, done_k, done_cnt); end
        checks++; if (n_addr_acc != 0 || bpos != 0) begin failures++; $display("FAIL len0_bus got=%0d/b%0d exp=0/b0", n_addr_acc, bpos); end
    endtask

    task automatic test_start_while_busy();
        int stray;
        bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        run_load(1, 0, 0, -1, 1'b0, 1'b1, -1, 40);
        checks++; if (done_k != 7 || done_cnt != 1 || n_addr_acc != 1) begin failures++; $display("FAIL busy_start got=%0d/%0d/%0d exp=7/1/1", done_k, done_cnt, n_addr_acc); end
        checks++; if (((wr_data.size() > 0) ? wr_data[0] : 32'hx) !== 32'hC4C3_C2C1) begin failures++; $display("FAIL busy_start_data got=%h exp=c4c3c2c1", (wr_data.size() > 0) ? wr_data[0] : 32'hx); end
        stray = 0;
        repeat (3) begin
            @(negedge HCLK);
            if (busy !== 1'b0 || HTRANS !== 2'b00) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL busy_start_idle got=%0d exp=0", stray); end
    endtask

    task automatic test_reset_mid();
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(2, 0, 0, -1, 1'b0, 1'b0, 1, 60);
        checks++; if (wr_addr.size() != 1 || HRESET !== 1'b1) begin failures++; $display("FAIL rstmid_reach got=%0d/%b exp=1/1", wr_addr.size(), HRESET); end
        @(negedge HCLK);
        checks++; if (HTRANS !== 2'b00 || HWRITE !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%h/%b/%b/%b exp=00/0/0/0", HTRANS, HWRITE, busy, s_ready); end
        checks++; if (HADDR !== BASE || HWDATA !== 32'h0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_regs got=%h/%h/%b exp=%h/0/0", HADDR, HWDATA, done, BASE); end
        HRESET = 1'b0; HREADY = 1'b1; HRESP = 1'b0; s_valid = 1'b0;
        @(negedge HCLK);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_gaps();
        test_wait_states();
        test_error();
        test_len_zero();
        test_start_while_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
